// File: rtl/miriscv_gpr_dump.sv
// Walks the GPR file in ascending order through a spare synchronous read port and
// streams {address, value} pairs on a valid/ready interface for debug/trace.
module miriscv_gpr_dump #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned GPR_ADDR_W = 5,
    parameter int unsigned GPR_DEPTH  = 2**GPR_ADDR_W,
    parameter int unsigned SKIP_X0    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [GPR_ADDR_W-1:0] gpr_raddr_o,
    input  logic [XLEN-1:0]       gpr_rdata_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [GPR_ADDR_W-1:0] dump_addr_o,
    output logic [XLEN-1:0]       dump_data_o
);

    localparam logic [GPR_ADDR_W-1:0] START_ADDR = GPR_ADDR_W'((SKIP_X0 != 0) ? 1 : 0);
    localparam logic [GPR_ADDR_W-1:0] LAST_ADDR  = GPR_ADDR_W'(GPR_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND
    } state_t;

    state_t                  state;
    logic [GPR_ADDR_W-1:0]   cnt;

    assign busy_o = (state != IDLE);

    // gpr_raddr_o runs one address ahead of cnt so the synchronous read port
    // has the next register's data ready in the READ cycle that follows a handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            gpr_raddr_o  <= '0;
            dump_valid_o <= 1'b0;
            dump_addr_o  <= '0;
            dump_data_o  <= '0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt         <= START_ADDR;
                    gpr_raddr_o <= START_ADDR;
                    if (start_i && !abort_i) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (abort_i) begin
                        state       <= IDLE;
                        cnt         <= START_ADDR;
                        gpr_raddr_o <= START_ADDR;
                    end else begin
                        dump_addr_o  <= cnt;
                        dump_data_o  <= (cnt == '0) ? '0 : gpr_rdata_i;
                        dump_valid_o <= 1'b1;
                        if (cnt != LAST_ADDR) begin
                            gpr_raddr_o <= cnt + GPR_ADDR_W'(1);
                        end
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        dump_valid_o <= 1'b0;
                        state        <= IDLE;
                        cnt          <= START_ADDR;
                        gpr_raddr_o  <= START_ADDR;
                    end else if (dump_ready_i) begin
                        dump_valid_o <= 1'b0;
                        if (cnt == LAST_ADDR) begin
                            done_o      <= 1'b1;
                            state       <= IDLE;
                            cnt         <= START_ADDR;
                            gpr_raddr_o <= START_ADDR;
                        end else begin
                            cnt   <= cnt + GPR_ADDR_W'(1);
                            state <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_gpr_dump.sv
// Scoreboard bench for miriscv_gpr_dump: an RV32I/SKIP_X0=1 instance and an
// RV32E/SKIP_X0=0 instance, each fed by a synchronous GPR read-port model.
module tb_miriscv_gpr_dump;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, abort_a, ready_a, busy_a, done_a, valid_a;
    logic [4:0]  raddr_a, addr_a;
    logic [31:0] rdata_a, data_a;
    logic        rst_b, start_b, abort_b, ready_b, busy_b, done_b, valid_b;
    logic [3:0]  raddr_b, addr_b;
    logic [31:0] rdata_b, data_b;

    logic [31:0] gpr_a [32];
    logic [31:0] gpr_b [16];

    miriscv_gpr_dump #(.XLEN(32), .GPR_ADDR_W(5), .GPR_DEPTH(32), .SKIP_X0(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .abort_i(abort_a),
        .busy_o(busy_a), .done_o(done_a), .gpr_raddr_o(raddr_a), .gpr_rdata_i(rdata_a),
        .dump_valid_o(valid_a), .dump_ready_i(ready_a), .dump_addr_o(addr_a),
        .dump_data_o(data_a)
    );

    miriscv_gpr_dump #(.XLEN(32), .GPR_ADDR_W(4), .GPR_DEPTH(16), .SKIP_X0(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .abort_i(abort_b),
        .busy_o(busy_b), .done_o(done_b), .gpr_raddr_o(raddr_b), .gpr_rdata_i(rdata_b),
        .dump_valid_o(valid_b), .dump_ready_i(ready_b), .dump_addr_o(addr_b),
        .dump_data_o(data_b)
    );

    // Synchronous read ports: data for an address appears one edge after it is presented.
    always @(posedge clk) begin
        rdata_a <= gpr_a[raddr_a];
        rdata_b <= gpr_b[raddr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    vectors = 0;
    int    miscompares = 0;
    pair_t exp_a[$];
    pair_t exp_b[$];
    bit    busy_m_a = 1'b0, done_exp_a = 1'b0, lat_chk = 1'b0;
    bit    busy_m_b = 1'b0, done_exp_b = 1'b0;
    bit    rdy_always = 1'b0;
    int    start_cyc = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: a dump delivers every register from the first walked index up
    // to the last, x0 reading as zero.
    function automatic void model_dump_a();
        for (int a = 1; a < 32; a++) exp_a.push_back('{addr: 5'(a), data: gpr_a[a]});
        busy_m_a   = 1'b1;
        done_exp_a = 1'b1;
    endfunction

    function automatic void model_dump_b();
        for (int a = 0; a < 16; a++) exp_b.push_back('{addr: 5'(a), data: (a == 0) ? 32'h0 : gpr_b[a]});
        busy_m_b   = 1'b1;
        done_exp_b = 1'b1;
    endfunction

    function automatic void model_cancel_a();
        exp_a.delete();
        busy_m_a   = 1'b0;
        done_exp_a = 1'b0;
    endfunction

    // Monitor A: checks every delivered pair, hold stability under backpressure, done_o.
    initial begin
        pair_t held;
        pair_t p;
        bit    held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                held_v = 1'b0;
            end else begin
                if (valid_a && held_v) begin
                    check("hold_addr", 32'(addr_a), 32'(held.addr));
                    check("hold_data", data_a, held.data);
                end
                held_v = valid_a && !ready_a && !abort_a;
                held   = '{addr: addr_a, data: data_a};
                if (valid_a && ready_a && !abort_a) begin
                    if (exp_a.size() == 0) begin
                        check("unexpected_pair_a", 32'(exp_a.size()), 32'(1));
                    end else begin
                        p = exp_a.pop_front();
                        check("pair_addr_a", 32'(addr_a), 32'(p.addr));
                        check("pair_data_a", data_a, p.data);
                    end
                end
                if (done_a) begin
                    check("done_expected_a", 32'(done_exp_a && exp_a.size() == 0), 32'(1));
                    check("busy_at_done_a", 32'(busy_a), 32'(0));
                    if (lat_chk) check("done_latency", 32'(cyc - start_cyc), 32'(62));
                    lat_chk    = 1'b0;
                    done_exp_a = 1'b0;
                    busy_m_a   = 1'b0;
                end
            end
        end
    end

    // Monitor B
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                if (valid_b && ready_b && !abort_b) begin
                    if (exp_b.size() == 0) begin
                        check("unexpected_pair_b", 32'(exp_b.size()), 32'(1));
                    end else begin
                        p = exp_b.pop_front();
                        check("pair_addr_b", 32'(addr_b), 32'(p.addr));
                        check("pair_data_b", data_b, p.data);
                    end
                end
                if (done_b) begin
                    check("done_expected_b", 32'(done_exp_b && exp_b.size() == 0), 32'(1));
                    done_exp_b = 1'b0;
                    busy_m_b   = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse_a(input bit with_abort);
        start_a = 1'b1;
        abort_a = with_abort;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        if (!with_abort && !busy_m_a) begin
            model_dump_a();
            start_cyc = cyc;
        end
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (busy_m_a && n < budget) begin
            ready_a = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("dump_finished_a", 32'(busy_m_a), 32'(0));
    endtask

    // Runs the walk until the target pair is presented, then holds it unaccepted.
    task automatic wait_addr_a(input logic [4:0] target, input int budget);
        int n = 0;
        while (!(valid_a && addr_a == target) && n < budget) begin
            ready_a = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready_a = 1'b0;
        check("reach_addr", 32'(addr_a), 32'(target));
    endtask

    task automatic check_zero_a();
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_done", 32'(done_a), 32'(0));
        check("rst_valid", 32'(valid_a), 32'(0));
        check("rst_addr", 32'(addr_a), 32'(0));
        check("rst_data", data_a, 32'h0);
        check("rst_raddr", 32'(raddr_a), 32'(0));
    endtask

    initial begin
        int n;
        {start_a, abort_a, ready_a, start_b, abort_b, ready_b} = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 32; i++) gpr_a[i] = 32'hA500_0000 + 32'(i);
        for (int i = 0; i < 16; i++) gpr_b[i] = $urandom;
        gpr_b[0] = 32'hFFFF_FFFF;
        repeat (3) tick();
        check_zero_a();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick();

        // T1: full dump, ready held high, done latency
        rdy_always = 1'b1;
        ready_a    = 1'b1;
        lat_chk    = 1'b1;
        start_pulse_a(1'b0);
        wait_idle_a(200);
        rdy_always = 1'b0;
        repeat (2) tick();

        // T2: backpressure on x7, plus a start while busy that must be ignored
        for (int i = 0; i < 32; i++) gpr_a[i] = $urandom;
        gpr_a[7] = 32'hDEAD_BEEF;
        start_pulse_a(1'b0);
        tick();
        start_pulse_a(1'b0);
        wait_addr_a(5'd7, 100);
        repeat (5) begin
            tick();
            check("bp_valid", 32'(valid_a), 32'(1));
            check("bp_addr", 32'(addr_a), 32'(7));
            check("bp_data", data_a, 32'hDEAD_BEEF);
        end
        wait_idle_a(400);
        repeat (4) tick();
        check("no_queued_start", 32'(busy_a), 32'(0));

        // T4: abort in SEND at x12, then restart from x1
        start_pulse_a(1'b0);
        wait_addr_a(5'd12, 200);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        model_cancel_a();
        check("abort_valid", 32'(valid_a), 32'(0));
        check("abort_busy", 32'(busy_a), 32'(0));
        tick();
        start_pulse_a(1'b0);
        wait_idle_a(400);

        // T5: reset mid-dump at x20
        start_pulse_a(1'b0);
        wait_addr_a(5'd20, 300);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        model_cancel_a();
        check_zero_a();
        repeat (3) tick();

        // T6: start with abort in IDLE; abort with the last handshake
        start_pulse_a(1'b1);
        check("start_abort_busy", 32'(busy_a), 32'(0));
        tick();
        check("start_abort_busy2", 32'(busy_a), 32'(0));
        start_pulse_a(1'b0);
        wait_addr_a(5'd31, 400);
        ready_a = 1'b1;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        ready_a = 1'b0;
        model_cancel_a();
        check("last_abort_done", 32'(done_a), 32'(0));
        check("last_abort_busy", 32'(busy_a), 32'(0));
        tick();
        check("last_abort_done2", 32'(done_a), 32'(0));

        // T3: RV32E walk from x0, x0 forced to zero
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        model_dump_b();
        n = 0;
        while (busy_m_b && n < 300) begin
            ready_b = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("dump_finished_b", 32'(busy_m_b), 32'(0));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
